// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon colour sequence player.
package simon_pkg;

    localparam int COLOUR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP,
        DONE
    } player_state_t;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] GRN = 2'd1;
    localparam logic [1:0] BLU = 2'd2;
    localparam logic [1:0] YEL = 2'd3;

endpackage

// File: rtl/sequence_player_dwell_timer.sv
// dwell_timer: loadable down-counter that holds at zero; expired while the count is zero.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays the first round_ctr+1 colours of a packed sequence with ON/GAP dwells.
// Define SEQUENCE_PLAYER_SPEEDUP_EN to shorten the ON dwell as the round number grows.
module sequence_player
    import simon_pkg::*;
#(
    parameter int COLOUR_W = COLOUR_W_DEF,
    parameter int MAX_LEN  = 16,
    parameter int CNT_W    = 16,
`ifdef SEQUENCE_PLAYER_SPEEDUP_EN
    parameter int MIN_ON    = 4,
    parameter int SPD_SHIFT = 2,
`endif
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [COLOUR_W*MAX_LEN-1:0] seq_in,
    input  logic [IDX_W-1:0]            round_ctr,
    input  logic [CNT_W-1:0]            on_cycles,
    input  logic [CNT_W-1:0]            gap_cycles,
    output logic [COLOUR_W-1:0]         colour_bus,
    output logic                        colour_oe,
    output logic                        busy,
    output logic                        complete
);

    localparam int SEQ_W = COLOUR_W * MAX_LEN;

    player_state_t        state_q, state_d;
    logic [IDX_W-1:0]     pos_q, pos_d, last_q, lastIn;
    logic [SEQ_W-1:0]     seq_q, seqCur;
    logic [CNT_W-1:0]     onLen_q, gapLen_q, onEff, onLenIn, timerValue;
    logic [COLOUR_W-1:0]  colourBus_q;
    logic                 colourOe_q, busy_q, complete_q;
    logic                 capture, timerLoad, timerExpired;

`ifdef SEQUENCE_PLAYER_SPEEDUP_EN
    localparam int WIDE_W = CNT_W + IDX_W + SPD_SHIFT;
    logic [WIDE_W-1:0] onWide, decWide, diffWide;

    // Saturating subtract of the round-scaled step, then floor at MIN_ON.
    always_comb begin
        onWide   = WIDE_W'(on_cycles);
        decWide  = WIDE_W'(round_ctr) << SPD_SHIFT;
        diffWide = (onWide > decWide) ? (onWide - decWide) : '0;
        if (diffWide < WIDE_W'(MIN_ON)) begin
            diffWide = WIDE_W'(MIN_ON);
        end
        onEff = CNT_W'(diffWide);
    end
`else
    assign onEff = on_cycles;
`endif

    // Timer reloads hold dwell-1; a zero dwell behaves as a single cycle.
    assign onLenIn = (onEff == '0) ? '0 : (onEff - CNT_W'(1));
    assign lastIn  = (int'(round_ctr) > MAX_LEN - 1) ? IDX_W'(MAX_LEN - 1) : round_ctr;
    assign seqCur  = capture ? seq_in : seq_q;

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        capture    = 1'b0;
        timerLoad  = 1'b0;
        timerValue = onLen_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    capture    = 1'b1;
                    state_d    = ON;
                    pos_d      = '0;
                    timerLoad  = 1'b1;
                    timerValue = onLenIn;
                end
            end
            ON: begin
                if (timerExpired) begin
                    if (pos_q == last_q) begin
                        state_d = DONE;
                    end else if (gapLen_q != '0) begin
                        state_d    = GAP;
                        timerLoad  = 1'b1;
                        timerValue = gapLen_q - CNT_W'(1);
                    end else begin
                        pos_d     = pos_q + IDX_W'(1);
                        timerLoad = 1'b1;
                    end
                end
            end
            GAP: begin
                if (timerExpired) begin
                    state_d   = ON;
                    pos_d     = pos_q + IDX_W'(1);
                    timerLoad = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            last_q      <= '0;
            seq_q       <= '0;
            onLen_q     <= '0;
            gapLen_q    <= '0;
            colourBus_q <= '0;
            colourOe_q  <= 1'b0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            if (capture) begin
                seq_q    <= seq_in;
                last_q   <= lastIn;
                onLen_q  <= onLenIn;
                gapLen_q <= gap_cycles;
            end
            // Outputs are registered from the next state so they line up with state_q.
            colourOe_q <= (state_d == ON);
            busy_q     <= (state_d != IDLE);
            complete_q <= (state_d == DONE);
            if (state_d == ON) begin
                colourBus_q <= seqCur[COLOUR_W*int'(pos_d) +: COLOUR_W];
            end
        end
    end

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timerLoad),
        .value_i  (timerValue),
        .expired_o(timerExpired)
    );

    assign colour_bus = colourBus_q;
    assign colour_oe  = colourOe_q;
    assign busy       = busy_q;
    assign complete   = complete_q;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: per-cycle expectations queued at start, popped on negedge.
module tb_sequence_player;

    localparam int COLOUR_W = 2;
    localparam int MAX_LEN  = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start, abort;
    logic [COLOUR_W*MAX_LEN-1:0] seq_in;
    logic [IDX_W-1:0]            round_ctr;
    logic [CNT_W-1:0]            on_cycles, gap_cycles;
    logic [COLOUR_W-1:0]         colour_bus;
    logic                        colour_oe, busy, complete;

    typedef struct {
        logic       oe;
        logic [1:0] bus;
        logic       busy;
        logic       done;
        logic       chkBus;
    } expT;

    expT expQ[$];
    int  testsRun    = 0;
    int  testsFailed = 0;

    sequence_player dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seq_in    (seq_in),
        .round_ctr (round_ctr),
        .on_cycles (on_cycles),
        .gap_cycles(gap_cycles),
        .colour_bus(colour_bus),
        .colour_oe (colour_oe),
        .busy      (busy),
        .complete  (complete)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input logic oe, input logic [1:0] bus, input logic bsy, input logic done, input logic chk);
        expT e;
        e.oe = oe; e.bus = bus; e.busy = bsy; e.done = done; e.chkBus = chk;
        expQ.push_back(e);
    endtask

    // Build the expected cycle-by-cycle trace, start playback, then drain the scoreboard.
    task automatic applyStimulus(input logic [31:0] seqVal, input int round, input int onC,
                                 input int gapC, input int abortAt, input int pokeAt);
        int         last, onEff, idx;
        logic [1:0] colour;
        expT        e;
        expQ.delete();
        last  = (round > MAX_LEN - 1) ? MAX_LEN - 1 : round;
`ifdef SEQUENCE_PLAYER_SPEEDUP_EN
        onEff = onC - (round << 2);
        if (onEff < 4) onEff = 4;
`else
        onEff = (onC == 0) ? 1 : onC;
`endif
        colour = 2'd0;
        for (int k = 0; k <= last; k++) begin
            colour = seqVal[2*k +: 2];
            for (int c = 0; c < onEff; c++) pushExp(1'b1, colour, 1'b1, 1'b0, 1'b1);
            if (k < last) begin
                for (int c = 0; c < gapC; c++) pushExp(1'b0, colour, 1'b1, 1'b0, 1'b1);
            end
        end
        pushExp(1'b0, colour, 1'b1, 1'b1, 1'b1);
        pushExp(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        if (abortAt >= 0) begin
            while (expQ.size() > abortAt + 1) void'(expQ.pop_back());
            pushExp(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            pushExp(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        seq_in     = seqVal;
        round_ctr  = IDX_W'(round);
        on_cycles  = CNT_W'(onC);
        gap_cycles = CNT_W'(gapC);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("oe[%0d]", idx), colour_oe, e.oe);
            checkOutput($sformatf("busy[%0d]", idx), busy, e.busy);
            checkOutput($sformatf("complete[%0d]", idx), complete, e.done);
            if (e.chkBus) checkOutput($sformatf("bus[%0d]", idx), colour_bus, e.bus);
            abort = (idx == abortAt);
            if (idx == pokeAt) begin
                start  = 1'b1;
                seq_in = ~seqVal;
            end else begin
                start = 1'b0;
            end
            idx++;
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        seq_in = '0; round_ctr = '0; on_cycles = '0; gap_cycles = '0;
        #12;
        checkOutput("rst_oe", colour_oe, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_complete", complete, 1'b0);
        checkOutput("rst_bus", colour_bus, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h0000_0039, 2, 3, 2, -1, -1);
        applyStimulus($urandom(), 15, 1, 0, -1, -1);
        applyStimulus(32'h0000_00E4, 3, 2, 3, 8, -1);
        applyStimulus(32'h0000_001B, 1, 2, 1, -1, -1);
        applyStimulus(32'h0000_0026, 2, 2, 1, -1, 2);
        applyStimulus(32'h0000_0007, 1, 0, 1, -1, -1);
        applyStimulus(32'h0000_0FAC, 5, 20, 1, -1, -1);

        @(negedge clk);
        seq_in = 32'h3; round_ctr = '0; on_cycles = 16'd4; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("startAbort_busy", busy, 1'b0);
        checkOutput("startAbort_oe", colour_oe, 1'b0);

        @(negedge clk);
        seq_in = 32'h3; round_ctr = '0; on_cycles = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("midOn_bus", colour_bus, 2'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRst_oe", colour_oe, 1'b0);
        checkOutput("asyncRst_busy", busy, 1'b0);
        checkOutput("asyncRst_bus", colour_bus, 2'd0);
        checkOutput("asyncRst_complete", complete, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("postRst_busy", busy, 1'b0);
            checkOutput("postRst_complete", complete, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
